// File: rtl/line_raster_pkg.sv
// Shared types for the Bresenham line rasteriser.
package line_raster_pkg;

    localparam int CW_DEFAULT = 11;

    typedef logic [CW_DEFAULT-1:0]        coord_t;
    typedef logic signed [CW_DEFAULT+1:0] err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/line_raster_stream_step.sv
// One combinational Bresenham advance: given the current point and error
// term, produce the next point and error term.
module bresenham_step #(
    parameter int CW = 11
) (
    input  logic [CW-1:0]        x,
    input  logic [CW-1:0]        y,
    input  logic signed [CW+1:0] err,
    input  logic [CW-1:0]        dx,
    input  logic [CW-1:0]        dy,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    output logic [CW-1:0]        nx,
    output logic [CW-1:0]        ny,
    output logic signed [CW+1:0] nerr
);

    logic signed [CW+2:0] e2;
    logic signed [CW+2:0] dx_w;
    logic signed [CW+2:0] dy_w;

    // Step decision at CW+3 bits so 2*err never overflows; x and y may both move.
    always_comb begin
        e2   = {err, 1'b0};
        dx_w = $signed({3'b000, dx});
        dy_w = $signed({3'b000, dy});
        nerr = err;
        nx   = x;
        ny   = y;
        if (e2 > -dy_w) begin
            nerr = nerr - $signed(dy_w[CW+1:0]);
            nx   = sx_neg ? x - 1'b1 : x + 1'b1;
        end
        if (e2 < dx_w) begin
            nerr = nerr + $signed(dx_w[CW+1:0]);
            ny   = sy_neg ? y - 1'b1 : y + 1'b1;
        end
    end

endmodule

// File: rtl/line_raster_stream.sv
// Bresenham line rasteriser streaming one pixel per cycle over valid/ready.
// Optional clipping against MAX_X/MAX_Y is compiled in with LINE_RASTER_CLIP_EN.
module line_raster_stream
    import line_raster_pkg::*;
#(
    parameter int CW    = 11,
    parameter int MAX_X = 640,
    parameter int MAX_Y = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    output logic          busy,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py,
    output logic          pvalid,
    input  logic          pready,
    output logic          done
);

    localparam logic [CW:0] MAX_X_C = (CW+1)'(MAX_X);
    localparam logic [CW:0] MAX_Y_C = (CW+1)'(MAX_Y);

    state_t               state_q, state_d;
    logic [CW-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]        px_q, px_d, py_q, py_d;
    logic [CW-1:0]        dx_q, dx_d, dy_q, dy_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [CW+1:0] err_q, err_d;

    logic [CW-1:0]        nx, ny;
    logic signed [CW+1:0] nerr;
    logic [CW-1:0]        abs_dx, abs_dy;
    logic                 vis, advance, at_end;

    bresenham_step #(.CW(CW)) u_step (
        .x(px_q), .y(py_q), .err(err_q), .dx(dx_q), .dy(dy_q),
        .sx_neg(sx_neg_q), .sy_neg(sy_neg_q),
        .nx(nx), .ny(ny), .nerr(nerr)
    );

`ifdef LINE_RASTER_CLIP_EN
    // Off-screen points are skipped without waiting for the consumer.
    assign vis = ({1'b0, px_q} < MAX_X_C) && ({1'b0, py_q} < MAX_Y_C);
`else
    logic unused_clip;
    assign unused_clip = ^{MAX_X_C, MAX_Y_C};
    assign vis = 1'b1;
`endif

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign pvalid  = (state_q == DRAW) && vis;
    assign px      = px_q;
    assign py      = py_q;
    assign at_end  = (px_q == x1_q) && (py_q == y1_q);
    assign advance = vis ? pready : 1'b1;
    assign abs_dx  = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
    assign abs_dy  = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;

    // Command FSM: latch endpoints, set up deltas, walk the line, pulse done.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        px_d     = px_q;
        py_d     = py_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d     = abs_dx;
                dy_d     = abs_dy;
                sx_neg_d = (x1_q < x0_q);
                sy_neg_d = (y1_q < y0_q);
                err_d    = $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
                px_d     = x0_q;
                py_d     = y0_q;
                state_d  = DRAW;
            end
            DRAW: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        px_d  = nx;
                        py_d  = ny;
                        err_d = nerr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            px_q     <= '0;
            py_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            px_q     <= px_d;
            py_q     <= py_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_line_raster_stream.sv
// Directed bench for line_raster_stream; expected values are hand-derived.
module tb_line_raster_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        busy, pvalid, done;
    logic [10:0] px, py;
    logic        pready = 1'b1;

    int checks = 0;
    int errors = 0;

    int hx[$];
    int hy[$];
    int first_cyc, done_cyc, last_hs, done_cnt;

    line_raster_stream #(.CW(11), .MAX_X(640), .MAX_Y(480)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .busy(busy), .px(px), .py(py), .pvalid(pvalid),
        .pready(pready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one line; mode 0 keeps pready high, mode 1 gives ready 1,0,0 repeating.
    task automatic run_line(input logic [10:0] ax0, input logic [10:0] ay0,
                            input logic [10:0] ax1, input logic [10:0] ay1,
                            input int mode, input string tag);
        logic        stall_prev;
        logic [10:0] ppx, ppy;
        hx.delete();
        hy.delete();
        first_cyc = -1; done_cyc = -1; last_hs = -1; done_cnt = 0;
        stall_prev = 1'b0; ppx = '0; ppy = '0;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            pready = (mode == 0) || ((c % 3) == 2);
            if (c == 1) begin
                check({tag, " busy_setup"}, busy, 1);
                check({tag, " pvalid_setup"}, pvalid, 0);
            end
            if (stall_prev) begin
                check({tag, " stall_pvalid"}, pvalid, 1);
                check({tag, " stall_px"}, px, ppx);
                check({tag, " stall_py"}, py, ppy);
            end
            if (pvalid && first_cyc < 0) first_cyc = c;
            if (pvalid && pready) begin
                hx.push_back(int'(px));
                hy.push_back(int'(py));
                last_hs = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check({tag, " busy_with_done"}, busy, 1);
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                check({tag, " busy_after_done"}, busy, 0);
                check({tag, " done_single"}, done, 0);
                break;
            end
            stall_prev = pvalid && !pready;
            ppx = px;
            ppy = py;
            tick();
            start = 1'b0;
        end
        start = 1'b0;
        pready = 1'b1;
        check({tag, " finished_in_budget"}, done_cyc >= 0, 1);
        check({tag, " done_count"}, done_cnt, 1);
    endtask

    initial begin
        int ys_a[11];
        int cnt;
        int hit_reset;
        ys_a = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3};

        // Reset state
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset pvalid", pvalid, 0);
        check("reset done", done, 0);
        check("reset px", px, 0);
        check("reset py", py, 0);
        reset = 1'b0;
        tick();

        // Shallow line (0,0)->(10,3)
        run_line(11'd0, 11'd0, 11'd10, 11'd3, 0, "shallow");
        check("shallow count", hx.size(), 11);
        check("shallow first_cyc", first_cyc, 2);
        check("shallow last_hs", last_hs, 12);
        check("shallow done_cyc", done_cyc, 13);
        for (int i = 0; i < 11 && i < hx.size(); i++) begin
            check("shallow px", hx[i], i);
            check("shallow py", hy[i], ys_a[i]);
        end

        // Steep, negative direction (5,20)->(2,0)
        run_line(11'd5, 11'd20, 11'd2, 11'd0, 0, "steep");
        check("steep count", hx.size(), 21);
        if (hx.size() == 21) begin
            check("steep first_x", hx[0], 5);
            check("steep last_x", hx[20], 2);
            for (int i = 0; i < 21; i++) check("steep py", hy[i], 20 - i);
            for (int i = 1; i < 21; i++) begin
                check("steep x_step", (hx[i-1] - hx[i]) inside {0, 1}, 1);
            end
        end

        // Degenerate single point
        run_line(11'd7, 11'd7, 11'd7, 11'd7, 0, "point");
        check("point count", hx.size(), 1);
        if (hx.size() == 1) begin
            check("point px", hx[0], 7);
            check("point py", hy[0], 7);
        end
        check("point done_cyc", done_cyc, 3);

        // Diagonal with backpressure
        run_line(11'd0, 11'd0, 11'd9, 11'd9, 1, "diag");
        check("diag count", hx.size(), 10);
        for (int i = 0; i < 10 && i < hx.size(); i++) begin
            check("diag px", hx[i], i);
            check("diag py", hy[i], i);
        end

        // Ignored start mid-line, then reset mid-line
        x0 = 11'd0; y0 = 11'd0; x1 = 11'd50; y1 = 11'd0;
        start = 1'b1;
        pready = 1'b1;
        cnt = 0;
        hit_reset = 0;
        for (int c = 0; c < 40 && hit_reset == 0; c++) begin
            check("abort done", done, 0);
            if (pvalid) begin
                check("abort px", px, cnt);
                if (cnt == 3) begin
                    start = 1'b1;
                    x0 = 11'd1; y0 = 11'd1; x1 = 11'd2; y1 = 11'd2;
                end
                if (cnt == 5) begin
                    reset = 1'b1;
                    hit_reset = 1;
                end
                cnt++;
            end
            tick();
            start = 1'b0;
        end
        check("abort reached_reset", hit_reset, 1);
        check("abort pvalid", pvalid, 0);
        check("abort busy", busy, 0);
        check("abort done_after", done, 0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort no_done", done, 0);
            check("abort idle", busy, 0);
        end

        run_line(11'd3, 11'd4, 11'd6, 11'd4, 0, "after_reset");
        check("after_reset count", hx.size(), 4);
        for (int i = 0; i < 4 && i < hx.size(); i++) begin
            check("after_reset px", hx[i], 3 + i);
            check("after_reset py", hy[i], 4);
        end

        // Line crossing the right clip edge
        run_line(11'd630, 11'd0, 11'd650, 11'd0, 0, "clip");
        check("clip done_cyc", done_cyc, 23);
`ifdef LINE_RASTER_CLIP_EN
        check("clip count", hx.size(), 10);
        if (hx.size() > 0) check("clip last_px", hx[hx.size()-1], 639);
`else
        check("clip count", hx.size(), 21);
        if (hx.size() > 0) check("clip last_px", hx[hx.size()-1], 650);
`endif
        if (hx.size() > 0) check("clip first_px", hx[0], 630);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_raster_stream.md
# line_raster_stream

Parametrised Bresenham line rasteriser that draws lines in all eight octants and streams one pixel coordinate per cycle over a valid/ready handshake. It has a start/busy/done command interface. It sits between the game's sprite/geometry sequencer and the framebuffer write port. Backpressure from the framebuffer stalls it without losing pixels.

## Interface
Parameters:
- CW, 11, coordinate width in bits (unsigned coordinates)
- MAX_X, 640, exclusive horizontal clip bound (used only with clipping compiled in)
- MAX_Y, 480, exclusive vertical clip bound (used only with clipping compiled in)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe; accepted only when busy=0
- x0, y0, x1, y1  in  CW each  endpoints; sampled only in the cycle start is accepted
- busy  out  1  high from the cycle after start is accepted until the cycle done is high (inclusive)
- px, py  out  CW each  current pixel coordinate
- pvalid  out  1  px/py hold a pixel to write
- pready  in  1  consumer accepts the pixel when pvalid && pready
- done  out  1  single-cycle pulse after the last pixel is accepted

## Operation
- Arithmetic widths:
  - dx = |x1−x0| and dy = |y1−y0| are CW-bit unsigned.
  - sx and sy are ±1.
  - err is a signed CW+2-bit value, initialised to dx−dy.
  - e2 = 2·err is evaluated at CW+3 bits. No overflow is permitted for any CW-bit endpoints.
- Step rule, applied on each advance:
  - if e2 > −dy: err −= dy and x += sx
  - if e2 < dx: err += dx and y += sy
  - Both conditions may apply in the same step, giving a diagonal move.
- Pixel count is exactly max(dx,dy)+1. Both endpoints are included, the first pixel is (x0,y0) and the last is (x1,y1). The line is emitted in order from endpoint 0 to endpoint 1, with no endpoint swapping.
- States:
  - IDLE: start → SETUP.
  - SETUP: latch dx/dy/sx/sy/err and load the point with (x0,y0) → DRAW.
  - DRAW: on handshake, if the current point equals (x1,y1) → DONE, else advance the point.
  - DONE: done=1 → IDLE.
- Stall: while pvalid && !pready, px, py, err and the state hold stable.
- start is ignored while busy=1. It is not queued.
- A degenerate line (x0==x1 and y0==y1) emits exactly one pixel.
- Reset at any time, including mid-line, forces IDLE and abandons the current line with no done pulse.
- Reset values:
  - busy=0, pvalid=0, done=0
  - px=0, py=0
  - internal err, dx, dy cleared

## Timing
- start accepted in cycle N:
  - busy=1 from N+1.
  - SETUP in N+1.
  - First pvalid=1 in N+2.
- With pready held high: one pixel per cycle. The last pixel is handshaked in cycle N+2+max(dx,dy). done=1 and busy=1 occur one cycle later, and busy=0 the cycle after that.
- Earliest next accepted start is the first cycle with busy=0.
- pvalid never drops without a handshake, except on reset.

## Configuration
- LINE_RASTER_CLIP_EN defined:
  - Points with px ≥ MAX_X or py ≥ MAX_Y are suppressed: pvalid=0 in that cycle, and the point advances one step per cycle with no handshake needed.
  - The point (x1,y1) ends the line whether or not it is visible.
  - done still pulses exactly once per line. A fully off-screen line produces zero handshakes followed by done.
- LINE_RASTER_CLIP_EN undefined: every point is emitted, and MAX_X and MAX_Y are ignored.

## Structure
- Package line_raster_pkg contains:
  - coord_t (logic [CW-1:0], via the package parameter default)
  - err_t (signed, CW+2 bits)
  - state enum {IDLE, SETUP, DRAW, DONE}
- Sub-module bresenham_step: purely combinational. It takes (x, y, err, dx, dy, sx, sy) and returns (next x, next y, next err). The top level owns the FSM, handshake and clip logic.

## Test plan
- (0,0)→(10,3), pready=1 → 11 pixels ending (10,3) on consecutive cycles, first pvalid 2 cycles after start, done one cycle after the last pixel.
- (5,20)→(2,0), steep with negative direction → 21 pixels, y strictly decreasing by 1 per pixel, first (5,20), last (2,0).
- (7,7)→(7,7) → exactly one pixel (7,7), then done.
- (0,0)→(9,9) with pready toggled 1,0,0,1,… → 10 pixels in order, px/py stable during every stall, no duplicates or drops.
- start at the 4th pixel of (0,0)→(50,0), then reset at the 6th pixel → start ignored, pvalid=0 and busy=0 the cycle after reset, no done; a new start then draws normally.
- With LINE_RASTER_CLIP_EN, MAX_X=640: (630,0)→(650,0) → only x=630..639 handshaked, then done. Without the macro → all 21 pixels.
